mux_probe_checker: RTL and testbench
====================================

Name: mux_probe_checker

Overview:
- Receiving end of the 9-bit internal-wire probe bus exported by the 2:1 mux under test.
- Drives the mux select/data inputs (S, I0, I1) through all 8 combinations and samples the probe vector after a settle delay.
- Compares each sample against a golden model and accumulates a per-wire error mask. Reports pass/fail and the first failing vector.
- Hardware replacement for the simulation-only checker; sits beside the mux in the self-test wrapper.

Parameters:
- SETTLE_CYCLES, 2, cycles between driving a vector and sampling the probe bus; range 0..15.
- PROBE_W, 9, probe bus width; fixed by the mux wire map; any other value is illegal.

Ports:
- clk  in  1  single clock; all logic on the rising edge.
- rst  in  1  synchronous, active-high reset.
- start  in  1  sampled in IDLE only; launches one sweep.
- s_o  out  1  registered select driven to the mux.
- i0_o  out  1  registered data-0 driven to the mux.
- i1_o  out  1  registered data-1 driven to the mux.
- probe_i  in  PROBE_W  observed mux wires; bit map matches the golden map below.
- busy  out  1  high from the cycle after start is accepted until DONE.
- done  out  1  one-cycle pulse in the DONE state.
- pass  out  1  valid from done onward: err_mask == 0.
- err_mask  out  PROBE_W  sticky OR of (probe_i XOR golden) over the sweep.
- first_fail_vec  out  3  {I0,I1,S} of the first mismatching vector.
- first_fail_valid  out  1  high once any mismatch has been seen this sweep.

Behaviour:
- Vector index vec[2:0] = {I0,I1,S}, swept 000 to 111 in ascending order.
- Golden map:
  - bit0 = I0, bit1 = I1
  - bits2..4 = S
  - bit5 = ~S
  - bit6 = I1&S, bit7 = I0&~S
  - bit8 = bit6|bit7
- FSM states: IDLE, SETTLE, SAMPLE, DONE.
- IDLE, start=1:
  - vec <= 0; drive vector 0.
  - Clear err_mask, first_fail_vec and first_fail_valid; clear settle counter.
  - Go to SETTLE, or to SAMPLE if SETTLE_CYCLES = 0.
- SETTLE: held exactly SETTLE_CYCLES cycles, then go to SAMPLE.
- SAMPLE:
  - err_mask <= err_mask | (probe_i ^ golden(vec)).
  - On a nonzero mismatch with first_fail_valid = 0: capture vec and set first_fail_valid.
  - If vec = 7, go to DONE. Otherwise vec++, drive the next vector, and go to SETTLE (or SAMPLE).
- DONE: done = 1 for one cycle, then go to IDLE.
- Timing:
  - Each vector takes SETTLE_CYCLES+1 cycles.
  - done asserts exactly 8*(SETTLE_CYCLES+1)+1 cycles after the edge that samples start (25 for the default).
- Result holding: pass, err_mask and first_fail_* hold their values in IDLE until the next accepted start.
- start is ignored in SETTLE, SAMPLE and DONE. No queuing; a level-held start re-launches only from IDLE.
- Stimulus outputs hold their last vector in IDLE.
- Reset values:
  - rst forces every output and register to 0 and the state to IDLE.
  - This applies on any cycle, including mid-sweep; rst has priority over start.
- pass reads 0 after reset, before any sweep.

Optional Feature:
- STOP_ON_FAIL_EN defined: SAMPLE goes to DONE on the first mismatching vector. err_mask then holds only that vector's mismatches, and done arrives early.
- STOP_ON_FAIL_EN undefined: always sweep all 8 vectors.

Decomposition:
- Package mux_check_pkg contains:
  - PROBE_W and NUM_VEC = 8
  - state enum
  - probe bit-index constants (IDX_I0 ... IDX_OUT)
- Sub-module mux_golden_model: combinational, vec[2:0] to golden[PROBE_W-1:0]; reused by the bench scoreboard.

Test Plan:
- Fault-free mux connected, start pulse -> done at cycle 25; pass=1; err_mask=9'h000; first_fail_valid=0.
- probe bit8 stuck-at-0 -> pass=0; err_mask=9'h100; first_fail_vec=3'b011; first_fail_valid=1.
- bit5 stuck-at-1 -> err_mask=9'h020; first_fail_vec=3'b001.
- bit2 and bit6 stuck-at-0 -> err_mask=9'h044; first_fail_vec=3'b001.
- rst high at cycle 10 of a sweep -> next cycle: busy=0, state IDLE, all outputs 0. A subsequent fault-free sweep gives pass=1 at cycle 25. start toggled during busy -> no restart, done still at cycle 25.
- STOP_ON_FAIL_EN defined, bit8 stuck-at-0 -> done at cycle 13; err_mask=9'h100; first_fail_vec=3'b011.

Source files
------------

// File: rtl/mux_check_pkg.sv
// mux_check_pkg: shared sizes, FSM encoding and probe-bus bit map for the mux probe checker
package mux_check_pkg;
  localparam int PROBE_W = 9;
  localparam int NUM_VEC = 8;
  localparam int IDX_I0  = 0;
  localparam int IDX_I1  = 1;
  localparam int IDX_S0  = 2;
  localparam int IDX_S1  = 3;
  localparam int IDX_S2  = 4;
  localparam int IDX_SN  = 5;
  localparam int IDX_A1  = 6;
  localparam int IDX_A0  = 7;
  localparam int IDX_OUT = 8;
  typedef enum logic [1:0] {IDLE, SETTLE, SAMPLE, DONE} state_e;
endpackage

// File: rtl/mux_golden_model.sv
// mux_golden_model: expected probe-bus value of a fault-free 2:1 mux for vector {I0,I1,S}
module mux_golden_model
  import mux_check_pkg::*;
(
  input  logic [2:0]         vec_i,
  output logic [PROBE_W-1:0] golden_o
);
  logic s, i0, i1;
  assign s  = vec_i[0];
  assign i1 = vec_i[1];
  assign i0 = vec_i[2];
  // Build the expected internal wire values of the mux for this vector
  always_comb begin
    golden_o          = '0;
    golden_o[IDX_I0]  = i0;
    golden_o[IDX_I1]  = i1;
    golden_o[IDX_S0]  = s;
    golden_o[IDX_S1]  = s;
    golden_o[IDX_S2]  = s;
    golden_o[IDX_SN]  = ~s;
    golden_o[IDX_A1]  = i1 & s;
    golden_o[IDX_A0]  = i0 & ~s;
    golden_o[IDX_OUT] = (i1 & s) | (i0 & ~s);
  end
endmodule

// File: rtl/mux_probe_checker.sv
// mux_probe_checker: sweeps all mux input vectors, checks the probe bus against a golden model (STOP_ON_FAIL_EN: end sweep at first mismatch)
module mux_probe_checker
  import mux_check_pkg::*;
#(
  parameter int SETTLE_CYCLES = 2
)
(
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  output logic               s_o,
  output logic               i0_o,
  output logic               i1_o,
  input  logic [PROBE_W-1:0] probe_i,
  output logic               busy,
  output logic               done,
  output logic               pass,
  output logic [PROBE_W-1:0] err_mask,
  output logic [2:0]         first_fail_vec,
  output logic               first_fail_valid
);
  localparam logic [3:0] LAST_CNT = 4'(SETTLE_CYCLES - 1);
  localparam logic [2:0] LAST_VEC = 3'(NUM_VEC - 1);
  localparam state_e     RUN_ST   = (SETTLE_CYCLES == 0) ? SAMPLE : SETTLE;
  state_e             state_q, state_d;
  logic [2:0]         vec_q, vec_d;
  logic [3:0]         cnt_q, cnt_d;
  logic [PROBE_W-1:0] err_q, err_d;
  logic [2:0]         ffv_q, ffv_d;
  logic               ffvalid_q, ffvalid_d;
  logic               pass_q, pass_d;
  logic [PROBE_W-1:0] golden, mism;
  logic               stop_hit;
  mux_golden_model u_golden (
    .vec_i    (vec_q),
    .golden_o (golden)
  );
  assign mism = probe_i ^ golden;
`ifdef STOP_ON_FAIL_EN
  assign stop_hit = |mism;
`else
  assign stop_hit = 1'b0;
`endif
  // Next-state logic: launch, settle wait, sample/accumulate, finish
  always_comb begin
    state_d   = state_q;
    vec_d     = vec_q;
    cnt_d     = cnt_q;
    err_d     = err_q;
    ffv_d     = ffv_q;
    ffvalid_d = ffvalid_q;
    pass_d    = pass_q;
    case (state_q)
      IDLE: if (start) begin
        vec_d     = '0;
        cnt_d     = '0;
        err_d     = '0;
        ffv_d     = '0;
        ffvalid_d = 1'b0;
        pass_d    = 1'b0;
        state_d   = RUN_ST;
      end
      SETTLE: begin
        state_d = (cnt_q == LAST_CNT) ? SAMPLE : SETTLE;
        cnt_d   = cnt_q + 4'd1;
      end
      SAMPLE: begin
        err_d     = err_q | mism;
        ffv_d     = (|mism && !ffvalid_q) ? vec_q : ffv_q;
        ffvalid_d = ffvalid_q | (|mism);
        if (vec_q == LAST_VEC || stop_hit) begin
          state_d = DONE;
          pass_d  = (err_d == '0);
        end else begin
          vec_d   = vec_q + 3'd1;
          cnt_d   = '0;
          state_d = RUN_ST;
        end
      end
      default: state_d = IDLE;
    endcase
  end
  // State and result registers with synchronous reset
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      vec_q     <= '0;
      cnt_q     <= '0;
      err_q     <= '0;
      ffv_q     <= '0;
      ffvalid_q <= 1'b0;
      pass_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      vec_q     <= vec_d;
      cnt_q     <= cnt_d;
      err_q     <= err_d;
      ffv_q     <= ffv_d;
      ffvalid_q <= ffvalid_d;
      pass_q    <= pass_d;
    end
  end
  assign {i0_o, i1_o, s_o} = vec_q;
  assign busy             = (state_q == SETTLE) || (state_q == SAMPLE);
  assign done             = (state_q == DONE);
  assign pass             = pass_q;
  assign err_mask         = err_q;
  assign first_fail_vec   = ffv_q;
  assign first_fail_valid = ffvalid_q;
endmodule

// File: tb/tb_mux_probe_checker.sv
// tb_mux_probe_checker: scoreboard bench driving a fault-injectable mux model into the checker
module tb_mux_probe_checker;
  typedef struct {
    int         lat;
    logic       pass;
    logic [8:0] err;
    logic [2:0] ffv;
    logic       ffvalid;
  } exp_t;
  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       start = 1'b0;
  logic       s_o, i0_o, i1_o, busy, done, pass, first_fail_valid;
  logic [8:0] probe, err_mask, sa0 = '0, sa1 = '0;
  logic [2:0] first_fail_vec;
  int         cyc = 0, start_cyc = 0, n_chk = 0, n_err = 0, n_done = 0;
  exp_t       sb[$];
  mux_probe_checker #(.SETTLE_CYCLES(2)) dut (
    .clk              (clk),
    .rst              (rst),
    .start            (start),
    .s_o              (s_o),
    .i0_o             (i0_o),
    .i1_o             (i1_o),
    .probe_i          (probe),
    .busy             (busy),
    .done             (done),
    .pass             (pass),
    .err_mask         (err_mask),
    .first_fail_vec   (first_fail_vec),
    .first_fail_valid (first_fail_valid)
  );
  function automatic logic [8:0] mux_wires(logic s, logic i0, logic i1);
    logic [8:0] w;
    w[0]   = i0;
    w[1]   = i1;
    w[4:2] = {3{s}};
    w[5]   = ~s;
    w[6]   = i1 & s;
    w[7]   = i0 & ~s;
    w[8]   = w[6] | w[7];
    return w;
  endfunction
  assign probe = (mux_wires(s_o, i0_o, i1_o) & ~sa0) | sa1;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask
  always @(negedge clk) begin
    if (!rst && done) begin
      if (sb.size() == 0) chk("unexpected_done", 32'(done), 32'd0);
      else begin
        exp_t e;
        e = sb.pop_front();
        chk("done_latency", 32'(cyc - start_cyc + 1), 32'(e.lat));
        chk("pass", 32'(pass), 32'(e.pass));
        chk("err_mask", 32'(err_mask), 32'(e.err));
        chk("first_fail_vec", 32'(first_fail_vec), 32'(e.ffv));
        chk("first_fail_valid", 32'(first_fail_valid), 32'(e.ffvalid));
      end
      n_done++;
    end
  end
  task automatic chk_zero(string nm);
    chk({nm, "_busy"}, 32'(busy), 32'd0);
    chk({nm, "_done"}, 32'(done), 32'd0);
    chk({nm, "_pass"}, 32'(pass), 32'd0);
    chk({nm, "_err"}, 32'(err_mask), 32'd0);
    chk({nm, "_ffv"}, 32'(first_fail_vec), 32'd0);
    chk({nm, "_ffvalid"}, 32'(first_fail_valid), 32'd0);
    chk({nm, "_stim"}, 32'({i0_o, i1_o, s_o}), 32'd0);
  endtask
  task automatic sweep(string nm, logic [8:0] a0, logic [8:0] a1, logic [8:0] err_full,
                       logic [8:0] err_stop, logic [2:0] ffv, bit toggle);
    exp_t e;
    int   target;
    logic [2:0] last;
    e.ffvalid = (err_full != 0);
    e.ffv     = ffv;
    e.pass    = (err_full == 0);
    e.err     = err_full;
    e.lat     = 25;
    last      = 3'd7;
`ifdef STOP_ON_FAIL_EN
    if (e.ffvalid) begin
      e.err = err_stop;
      e.lat = 3 * (int'(ffv) + 1) + 1;
      last  = ffv;
    end
`endif
    sa0 = a0;
    sa1 = a1;
    @(negedge clk);
    sb.push_back(e);
    target    = n_done + 1;
    start_cyc = cyc + 1;
    start     = 1'b1;
    @(negedge clk);
    start = 1'b0;
    for (int i = 0; i < 200 && n_done < target; i++) begin
      start = toggle && busy && (i % 4 == 1);
      @(negedge clk);
    end
    start = 1'b0;
    chk({nm, "_timeout"}, 32'(n_done >= target), 32'd1);
    repeat (3) @(negedge clk);
    chk({nm, "_idle_busy"}, 32'(busy), 32'd0);
    chk({nm, "_hold_pass"}, 32'(pass), 32'(e.pass));
    chk({nm, "_hold_err"}, 32'(err_mask), 32'(e.err));
    chk({nm, "_hold_stim"}, 32'({i0_o, i1_o, s_o}), 32'(last));
  endtask
  initial begin
    repeat (3) @(negedge clk);
    chk_zero("reset");
    rst = 1'b0;
    @(negedge clk);
    chk("pass_before_sweep", 32'(pass), 32'd0);
    sweep("clean", 9'h000, 9'h000, 9'h000, 9'h000, 3'd0, 1'b0);
    sweep("b8_sa0", 9'h100, 9'h000, 9'h100, 9'h100, 3'b011, 1'b0);
    sweep("b5_sa1", 9'h000, 9'h020, 9'h020, 9'h020, 3'b001, 1'b0);
    sweep("b2b6_sa0", 9'h044, 9'h000, 9'h044, 9'h004, 3'b001, 1'b0);
    sweep("b0_sa1", 9'h000, 9'h001, 9'h001, 9'h001, 3'b000, 1'b0);
    sa0 = 9'h100;
    sa1 = 9'h000;
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (8) @(negedge clk);
    chk("mid_busy", 32'(busy), 32'd1);
    rst = 1'b1;
    @(negedge clk);
    chk_zero("mid_rst");
    rst = 1'b0;
    @(negedge clk);
    sweep("after_rst", 9'h000, 9'h000, 9'h000, 9'h000, 3'd0, 1'b1);
    chk("scoreboard_empty", 32'(sb.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end
  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end
endmodule
